// File: rtl/shift_pipe.sv
// rtl/shift_pipe.sv - pipelined barrel shifter (SHL/SHR/SRA); ROL/ROR when SHIFT_PIPE_ROTATE_EN is defined
module shift_pipe #(
  parameter int BITS = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               op,
  input  logic [BITS-1:0]          a,
  input  logic [$clog2(BITS)-1:0]  b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BITS-1:0]          out
);

  localparam int SH = $clog2(BITS);
  localparam int L  = SH;

  // Per-stage registers; amt_q is kept left-aligned so the MSB is always
  // the amount bit the next stage consumes.
  logic [BITS-1:0] d_q   [L];
  logic            v_q   [L];
  logic            dir_q [L];
  logic            pad_q [L];
  logic [SH-1:0]   amt_q [L];
`ifdef SHIFT_PIPE_ROTATE_EN
  logic            rot_q [L];
`endif

  // Stage inputs: stage 0 sees the operand ports, stage k sees stage k-1.
  logic [BITS-1:0] s_d   [L];
  logic            s_v   [L];
  logic            s_dir [L];
  logic            s_pad [L];
  logic [SH-1:0]   s_amt [L];
`ifdef SHIFT_PIPE_ROTATE_EN
  logic            s_rot [L];
`endif
  logic [BITS-1:0] nxt_d [L];

  logic adv;

  // Global stall: the whole pipe moves only when the output slot frees up.
  assign adv       = out_ready | ~out_valid;
  assign in_ready  = adv;
  assign out       = d_q[L-1];
  assign out_valid = v_q[L-1];

  // Route the operand ports into stage 0 and each register set into the next stage.
  always_comb begin
    s_d[0]   = a;
    s_v[0]   = in_valid;
    s_dir[0] = op[0];
    s_amt[0] = b;
`ifdef SHIFT_PIPE_ROTATE_EN
    s_rot[0] = op[2];
    s_pad[0] = op[0] & op[1] & ~op[2] & a[BITS-1];
`else
    s_pad[0] = op[0] & op[1] & a[BITS-1];
`endif
    for (int k = 1; k < L; k++) begin
      s_d[k]   = d_q[k-1];
      s_v[k]   = v_q[k-1];
      s_dir[k] = dir_q[k-1];
      s_pad[k] = pad_q[k-1];
      s_amt[k] = amt_q[k-1];
`ifdef SHIFT_PIPE_ROTATE_EN
      s_rot[k] = rot_q[k-1];
`endif
    end
  end

  // Stage k shifts by 2^(L-1-k) when its amount bit is set, largest step first.
  always_comb begin
    for (int k = 0; k < L; k++) begin
      int unsigned sh;
      sh = 1 << (L - 1 - k);
      nxt_d[k] = s_d[k];
      if (s_amt[k][SH-1]) begin
        if (s_dir[k]) begin
          nxt_d[k] = (s_d[k] >> sh) | ({BITS{s_pad[k]}} << (BITS - sh));
`ifdef SHIFT_PIPE_ROTATE_EN
          if (s_rot[k]) nxt_d[k] = (s_d[k] >> sh) | (s_d[k] << (BITS - sh));
`endif
        end else begin
          nxt_d[k] = s_d[k] << sh;
`ifdef SHIFT_PIPE_ROTATE_EN
          if (s_rot[k]) nxt_d[k] = (s_d[k] << sh) | (s_d[k] >> (BITS - sh));
`endif
        end
      end
    end
  end

  // Pipeline registers: clear everything on reset, advance all stages together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < L; k++) begin
        d_q[k]   <= '0;
        v_q[k]   <= 1'b0;
        dir_q[k] <= 1'b0;
        pad_q[k] <= 1'b0;
        amt_q[k] <= '0;
`ifdef SHIFT_PIPE_ROTATE_EN
        rot_q[k] <= 1'b0;
`endif
      end
    end else if (adv) begin
      for (int k = 0; k < L; k++) begin
        d_q[k]   <= nxt_d[k];
        v_q[k]   <= s_v[k];
        dir_q[k] <= s_dir[k];
        pad_q[k] <= s_pad[k];
        amt_q[k] <= s_amt[k] << 1;
`ifdef SHIFT_PIPE_ROTATE_EN
        rot_q[k] <= s_rot[k];
`endif
      end
    end
  end

  // Last-stage control bits have no consumer; without rotate op[2] is a don't-care.
  logic unused_ok;
`ifdef SHIFT_PIPE_ROTATE_EN
  assign unused_ok = ^{dir_q[L-1], pad_q[L-1], rot_q[L-1], amt_q[L-1]};
`else
  assign unused_ok = ^{dir_q[L-1], pad_q[L-1], amt_q[L-1], op[2]};
`endif

endmodule

// File: tb/tb_shift_pipe.sv
// tb/tb_shift_pipe.sv - randomized and directed bench for shift_pipe
module tb_shift_pipe;

  localparam int BITS = 32;
  localparam int SH   = $clog2(BITS);
  localparam int L    = SH;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [2:0]      op = 3'b000;
  logic [BITS-1:0] a = '0;
  logic [SH-1:0]   b = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [BITS-1:0] out;

  always #5 clk = ~clk;

  shift_pipe #(.BITS(BITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int retire_cnt = 0;
  int streak = 0;
  int max_streak = 0;
  logic [BITS-1:0] exp_q [$];

  task automatic check(input string tag, input logic [BITS-1:0] got, input logic [BITS-1:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, expv);
    end
  endtask

  function automatic logic [BITS-1:0] ref_shift(input logic [2:0] o, input logic [BITS-1:0] x,
                                                input int unsigned n);
    logic [2*BITS-1:0] dbl;
`ifdef SHIFT_PIPE_ROTATE_EN
    if (o[2]) begin
      if (o[0]) begin
        dbl = {x, x} >> n;
        return dbl[BITS-1:0];
      end
      dbl = {x, x} << n;
      return dbl[2*BITS-1:BITS];
    end
`endif
    dbl = '0;
    if (!o[0]) return x << n;
    if (o[1])  return $signed(x) >>> n;
    return x >> n;
  endfunction

  task automatic step(input logic iv, input logic [2:0] o, input logic [BITS-1:0] x,
                      input logic [SH-1:0] amt, input logic ordy);
    @(negedge clk);
    in_valid = iv; op = o; a = x; b = amt; out_ready = ordy;
    #1;
    if (out_valid) begin
      streak++;
      if (streak > max_streak) max_streak = streak;
    end else begin
      streak = 0;
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) check("spurious_valid", {{(BITS-1){1'b0}}, out_valid}, '0);
      else begin
        check("result", out, exp_q.pop_front());
        retire_cnt++;
      end
    end
    if (in_valid && in_ready) exp_q.push_back(ref_shift(o, x, amt));
  endtask

  task automatic directed(input string tag, input logic [2:0] o, input logic [BITS-1:0] x,
                          input logic [SH-1:0] amt, input logic [BITS-1:0] expv);
    int lat;
    @(negedge clk);
    in_valid = 1'b1; op = o; a = x; b = amt; out_ready = 1'b1;
    #1;
    check({tag, "_in_ready"}, {{(BITS-1){1'b0}}, in_ready}, 1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) break;
      @(negedge clk);
      lat++;
    end
    check({tag, "_valid"}, {{(BITS-1){1'b0}}, out_valid}, 1);
    check({tag, "_latency"}, lat, L - 1);
    check(tag, out, expv);
    @(negedge clk);
  endtask

  initial begin
    logic [BITS-1:0] held;
    logic [BITS-1:0] ror_exp, rol_exp;

    repeat (2) @(negedge clk);
    check("reset_out_valid", {{(BITS-1){1'b0}}, out_valid}, 0);
    check("reset_out", out, 0);
    rst_n = 1'b1;
    #1;
    check("release_in_ready", {{(BITS-1){1'b0}}, in_ready}, 1);

`ifdef SHIFT_PIPE_ROTATE_EN
    ror_exp = 32'h1000_000F;
    rol_exp = 32'h0000_0003;
`else
    ror_exp = 32'h0000_000F;
    rol_exp = 32'h0000_0002;
`endif
    directed("shl_1_31",   3'b000, 32'h0000_0001, 5'd31, 32'h8000_0000);
    directed("shl_ff_0",   3'b000, 32'hFFFF_FFFF, 5'd0,  32'hFFFF_FFFF);
    directed("sra_8_4",    3'b011, 32'h8000_0000, 5'd4,  32'hF800_0000);
    directed("shr_8_4",    3'b001, 32'h8000_0000, 5'd4,  32'h0800_0000);
    directed("sra_7f_31",  3'b011, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000);
    directed("op010_shl",  3'b010, 32'h0000_0003, 5'd2,  32'h0000_000C);
    directed("ror_f1_4",   3'b101, 32'h0000_00F1, 5'd4,  ror_exp);
    directed("rol_81_1",   3'b100, 32'h8000_0001, 5'd1,  rol_exp);

    // Eight back-to-back ops must emerge as eight consecutive valid cycles.
    retire_cnt = 0; streak = 0; max_streak = 0;
    for (int i = 0; i < 8; i++)
      step(1'b1, 3'($urandom_range(0, 7)), $urandom, SH'($urandom_range(0, BITS-1)), 1'b1);
    for (int i = 0; i < 2*L; i++) step(1'b0, 3'b000, '0, '0, 1'b1);
    check("burst_retired", retire_cnt, 8);
    check("burst_streak", max_streak, 8);

    // Fill the pipe against a stalled consumer, hold three cycles, then drain.
    retire_cnt = 0;
    for (int i = 0; i < L + 2; i++)
      step(1'b1, 3'($urandom_range(0, 7)), $urandom, SH'($urandom_range(0, BITS-1)), 1'b0);
    check("stall_accepted", exp_q.size(), L);
    held = out;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 3'b000, $urandom, '0, 1'b0);
      check("stall_out", out, held);
      check("stall_valid", {{(BITS-1){1'b0}}, out_valid}, 1);
      check("stall_in_ready", {{(BITS-1){1'b0}}, in_ready}, 0);
    end
    for (int i = 0; i < 2*L; i++) step(1'b0, 3'b000, '0, '0, 1'b1);
    check("stall_retired", retire_cnt, L);
    check("stall_drained", exp_q.size(), 0);

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)), $urandom,
           SH'($urandom_range(0, BITS-1)), $urandom_range(0, 9) < 7);
    for (int i = 0; i < 3*L; i++) step(1'b0, 3'b000, '0, '0, 1'b1);
    check("random_drained", exp_q.size(), 0);

    // Asynchronous reset with the pipe full and a result on the output.
    for (int i = 0; i < L + 1; i++)
      step(1'b1, 3'b000, $urandom | 32'h1, '0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_out_valid", {{(BITS-1){1'b0}}, out_valid}, 0);
    check("midreset_out", out, 0);
    exp_q.delete();
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midreset_in_ready", {{(BITS-1){1'b0}}, in_ready}, 1);
    for (int i = 0; i < 2*L; i++) step(1'b0, 3'b000, '0, '0, 1'b1);
    directed("post_reset", 3'b001, 32'hF000_0000, 5'd8, 32'h00F0_0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
